// File: rtl/pixel_projection_accum.sv
// Per-frame row/column projection of thresholded pixels, read back through a registered port.
// Optional `PROJ_PIXEL_TOTAL_EN adds oTOTAL, the count of set pixels in the last capture.
module pixel_projection_accum #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int DATA_W   = 12,
    parameter int CNT_W    = 10
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iDVAL,
    input  logic              iFVAL,
    input  logic [7:0]        iTHRESH,
    input  logic              iSTART,
    input  logic              iRD_SEL,
    input  logic [CNT_W-1:0]  iRD_ADDR,
    output logic [CNT_W-1:0]  oRD_DATA,
    output logic              oBUSY,
    output logic              oDONE,
`ifdef PROJ_PIXEL_TOTAL_EN
    output logic [18:0]       oTOTAL,
`endif
    output logic [CNT_W-1:0]  oLINES
);

    localparam int ROW_AW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int COL_AW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_ACTIVE - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ACCUM, S_DONE} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic b);
        if (v == {CNT_W{1'b1}})
            return v;
        else
            return v + CNT_W'(b);
    endfunction

    state_t r_state;
    state_t w_state_nxt;

    logic             r_fval_d;
    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_y;
    logic [CNT_W-1:0] r_rowsum;
    logic [CNT_W-1:0] r_lines;
    logic [CNT_W-1:0] r_rd_data;
    logic             r_fin_p1;
    logic             r_col_vld_p1;
    logic             r_row_vld_p1;

    logic [COL_AW-1:0] r_x_p1;
    logic              r_y0_p1;
    logic              r_b_p1;
    logic [CNT_W-1:0]  r_col_rd_p1;
    logic [ROW_AW-1:0] r_row_addr_p1;
    logic [CNT_W-1:0]  r_row_sum_p1;

    logic [CNT_W-1:0] r_row_mem [V_ACTIVE];
    logic [CNT_W-1:0] r_col_mem [H_ACTIVE];

    logic w_pix_b;
    logic w_fval_rise;
    logic w_acc;
    logic w_line_end;
    logic w_fin;
    logic w_arm;
    logic w_busy;

    assign w_pix_b     = (iDATA[DATA_W-1 -: 8] > iTHRESH);
    assign w_fval_rise = iFVAL & ~r_fval_d;
    assign w_busy      = (r_state == S_ARMED) || (r_state == S_ACCUM);
    // Once the finishing condition is seen, no further pixels are taken while the last write drains.
    assign w_acc       = (r_state == S_ACCUM) && !r_fin_p1 && iDVAL && iFVAL;
    assign w_line_end  = w_acc && (r_x == X_LAST);
    assign w_fin       = (r_state == S_ACCUM) && !r_fin_p1 &&
                         ((w_line_end && (r_y == Y_LAST)) || !iFVAL);
    assign w_arm       = ((r_state == S_IDLE) || (r_state == S_DONE)) && iSTART;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (iSTART)      w_state_nxt = S_ARMED;
            S_ARMED: if (w_fval_rise) w_state_nxt = S_ACCUM;
            S_ACCUM: if (r_fin_p1)    w_state_nxt = S_DONE;
            S_DONE:  if (iSTART)      w_state_nxt = S_ARMED;
            default:                  w_state_nxt = S_IDLE;
        endcase
    end

    // p0: pixel acceptance, position tracking, control state
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state      <= S_IDLE;
            r_fval_d     <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_rowsum     <= '0;
            r_lines      <= '0;
            r_fin_p1     <= 1'b0;
            r_col_vld_p1 <= 1'b0;
            r_row_vld_p1 <= 1'b0;
            r_rd_data    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_fval_d     <= iFVAL;
            r_fin_p1     <= w_fin;
            r_col_vld_p1 <= w_acc;
            r_row_vld_p1 <= w_line_end;
            if (w_arm) begin
                r_x      <= '0;
                r_y      <= '0;
                r_rowsum <= '0;
                r_lines  <= '0;
            end else if (w_acc) begin
                if (w_line_end) begin
                    r_x      <= '0;
                    r_y      <= r_y + CNT_W'(1);
                    r_lines  <= r_lines + CNT_W'(1);
                    r_rowsum <= '0;
                end else begin
                    r_x      <= r_x + CNT_W'(1);
                    r_rowsum <= sat_inc(r_rowsum, w_pix_b);
                end
            end
            if (w_busy)
                r_rd_data <= '0;
            else if (iRD_SEL)
                r_rd_data <= (int'(iRD_ADDR) < H_ACTIVE) ? r_col_mem[iRD_ADDR[COL_AW-1:0]] : '0;
            else
                r_rd_data <= (int'(iRD_ADDR) < V_ACTIVE) ? r_row_mem[iRD_ADDR[ROW_AW-1:0]] : '0;
        end
    end

    // p1: column read captured at accept, both memories written one cycle later
    always_ff @(posedge iCLK) begin
        r_x_p1        <= r_x[COL_AW-1:0];
        r_y0_p1       <= (r_y == '0);
        r_b_p1        <= w_pix_b;
        r_col_rd_p1   <= r_col_mem[r_x[COL_AW-1:0]];
        r_row_addr_p1 <= r_y[ROW_AW-1:0];
        r_row_sum_p1  <= sat_inc(r_rowsum, w_pix_b);
        if (r_col_vld_p1)
            r_col_mem[r_x_p1] <= r_y0_p1 ? CNT_W'(r_b_p1) : sat_inc(r_col_rd_p1, r_b_p1);
        if (r_row_vld_p1)
            r_row_mem[r_row_addr_p1] <= r_row_sum_p1;
    end

`ifdef PROJ_PIXEL_TOTAL_EN
    logic [18:0] r_total;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST)
            r_total <= '0;
        else if (w_arm)
            r_total <= '0;
        else if (w_acc && w_pix_b)
            r_total <= r_total + 19'd1;
    end

    assign oTOTAL = r_total;
`endif

    assign oRD_DATA = r_rd_data;
    assign oBUSY    = w_busy;
    assign oDONE    = (r_state == S_DONE);
    assign oLINES   = r_lines;

endmodule

// File: tb/tb_pixel_projection_accum.sv
// Directed bench for pixel_projection_accum on a reduced 32x8 frame with 5-bit sums.
// Covers saturation, threshold equality, checkerboard, short frame, mid-capture reset.
module tb_pixel_projection_accum;

    localparam int H  = 32;
    localparam int V  = 8;
    localparam int DW = 12;
    localparam int CW = 5;

    logic          iCLK = 1'b0;
    logic          iRST;
    logic [DW-1:0] iDATA;
    logic          iDVAL;
    logic          iFVAL;
    logic [7:0]    iTHRESH;
    logic          iSTART;
    logic          iRD_SEL;
    logic [CW-1:0] iRD_ADDR;
    logic [CW-1:0] oRD_DATA;
    logic          oBUSY;
    logic          oDONE;
    logic [CW-1:0] oLINES;
`ifdef PROJ_PIXEL_TOTAL_EN
    logic [18:0]   oTOTAL;
`endif

    int total = 0;
    int bad   = 0;

    pixel_projection_accum #(
        .H_ACTIVE(H), .V_ACTIVE(V), .DATA_W(DW), .CNT_W(CW)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iDVAL(iDVAL), .iFVAL(iFVAL),
        .iTHRESH(iTHRESH), .iSTART(iSTART), .iRD_SEL(iRD_SEL), .iRD_ADDR(iRD_ADDR),
        .oRD_DATA(oRD_DATA), .oBUSY(oBUSY), .oDONE(oDONE),
`ifdef PROJ_PIXEL_TOTAL_EN
        .oTOTAL(oTOTAL),
`endif
        .oLINES(oLINES)
    );

    always #5 iCLK = ~iCLK;

    initial begin
        #500000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    function automatic logic [DW-1:0] pix(input int pat, input int x, input int y);
        case (pat)
            0:       return 12'hFFF;
            1:       return x[0] ? 12'h810 : 12'h800;
            2:       return (((x ^ y) & 1) != 0) ? 12'hFFF : 12'h000;
            3:       return (x < 4) ? 12'hFFF : 12'h000;
            default: return 12'h000;
        endcase
    endfunction

    task automatic start_cap();
        iSTART = 1'b1;
        tick();
        iSTART = 1'b0;
        check("busy_armed", {31'd0, oBUSY}, 1);
        check("done_clr", {31'd0, oDONE}, 0);
        check("lines_clr", {27'd0, oLINES}, 0);
    endtask

    task automatic run_frame(input int pat, input int nlines, input int extra, input bit full);
        int n;
        iFVAL    = 1'b1;
        iRD_SEL  = 1'b0;
        iRD_ADDR = '0;
        tick();
        tick();
        for (int y = 0; y < nlines; y++) begin
            for (int x = 0; x < H; x++) begin
                iDATA = pix(pat, x, y);
                iDVAL = 1'b1;
                tick();
                if (y == 1 && x == 0)
                    check("rd_busy", {27'd0, oRD_DATA}, 0);
                if (full && y == V - 1 && x == H - 1) begin
                    iDVAL = 1'b0;
                    check("done_lat1", {31'd0, oDONE}, 0);
                    tick();
                    check("done_lat2", {31'd0, oDONE}, 1);
                end
            end
            iDVAL = 1'b0;
            tick();
            tick();
        end
        for (int x = 0; x < extra; x++) begin
            iDATA = pix(pat, x, nlines);
            iDVAL = 1'b1;
            tick();
        end
        iDVAL = 1'b0;
        iFVAL = 1'b0;
        n = 0;
        while (oDONE !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("done_wait", {31'd0, oDONE}, 1);
    endtask

    task automatic check_mem(input string tag, input logic sel, input int addr, input int exp);
        iRD_SEL  = sel;
        iRD_ADDR = addr[CW-1:0];
        tick();
        check($sformatf("%s[%0d]", tag, addr), {27'd0, oRD_DATA}, exp);
    endtask

    initial begin
        iRST     = 1'b1;
        iDATA    = '0;
        iDVAL    = 1'b0;
        iFVAL    = 1'b0;
        iTHRESH  = 8'h80;
        iSTART   = 1'b0;
        iRD_SEL  = 1'b0;
        iRD_ADDR = '0;
        tick();
        tick();
        check("rst_busy", {31'd0, oBUSY}, 0);
        check("rst_done", {31'd0, oDONE}, 0);
        check("rst_lines", {27'd0, oLINES}, 0);
        check("rst_rd", {27'd0, oRD_DATA}, 0);
`ifdef PROJ_PIXEL_TOTAL_EN
        check("rst_total", {13'd0, oTOTAL}, 0);
`endif
        iRST = 1'b0;
        tick();

        // all pixels set: row sums saturate at 31, columns reach 8
        start_cap();
        run_frame(0, V, 0, 1'b1);
        check("A_lines", {27'd0, oLINES}, V);
        for (int r = 0; r < V; r++) check_mem("A_row", 1'b0, r, 31);
        for (int c = 0; c < H; c++) check_mem("A_col", 1'b1, c, V);
        check_mem("A_row_oor", 1'b0, V, 0);
`ifdef PROJ_PIXEL_TOTAL_EN
        check("A_total", {13'd0, oTOTAL}, 256);
`endif

        // even columns sit exactly at threshold (not counted), odd columns just above
        start_cap();
        run_frame(1, V, 0, 1'b1);
        for (int r = 0; r < V; r++) check_mem("B_row", 1'b0, r, 16);
        for (int c = 0; c < H; c++) check_mem("B_col", 1'b1, c, (c % 2 == 1) ? V : 0);
`ifdef PROJ_PIXEL_TOTAL_EN
        check("B_total", {13'd0, oTOTAL}, 128);
`endif

        start_cap();
        run_frame(2, V, 0, 1'b1);
        check("C_lines", {27'd0, oLINES}, V);
        for (int r = 0; r < V; r++) check_mem("C_row", 1'b0, r, 16);
        for (int c = 0; c < H; c++) check_mem("C_col", 1'b1, c, 4);
`ifdef PROJ_PIXEL_TOTAL_EN
        check("C_total", {13'd0, oTOTAL}, 128);
`endif

        // short frame: 3 lines plus 5 pixels, remaining rows keep checkerboard sums
        start_cap();
        run_frame(0, 3, 5, 1'b0);
        check("D_lines", {27'd0, oLINES}, 3);
        for (int r = 0; r < V; r++) check_mem("D_row", 1'b0, r, (r < 3) ? 31 : 16);
        for (int c = 0; c < H; c++) check_mem("D_col", 1'b1, c, (c < 5) ? 4 : 3);
`ifdef PROJ_PIXEL_TOTAL_EN
        check("D_total", {13'd0, oTOTAL}, 101);
`endif

        // reset in the middle of accumulation
        start_cap();
        iFVAL = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 40; k++) begin
            iDATA = 12'hFFF;
            iDVAL = 1'b1;
            tick();
        end
        check("E_mid_lines", {27'd0, oLINES}, 1);
        iRST = 1'b1;
        #2;
        check("E_rst_busy", {31'd0, oBUSY}, 0);
        check("E_rst_done", {31'd0, oDONE}, 0);
        check("E_rst_lines", {27'd0, oLINES}, 0);
        check("E_rst_rd", {27'd0, oRD_DATA}, 0);
        iDVAL = 1'b0;
        iFVAL = 1'b0;
        tick();
        iRST = 1'b0;
        tick();
        check("E_idle_busy", {31'd0, oBUSY}, 0);

        start_cap();
        run_frame(3, V, 0, 1'b1);
        check("F_lines", {27'd0, oLINES}, V);
        for (int r = 0; r < V; r++) check_mem("F_row", 1'b0, r, 4);
        for (int c = 0; c < H; c++) check_mem("F_col", 1'b1, c, (c < 4) ? V : 0);
`ifdef PROJ_PIXEL_TOTAL_EN
        check("F_total", {13'd0, oTOTAL}, 32);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
